// File: rtl/reg_dump_uart.sv
// Register-file dump over UART 8N1: walks x0..x31 through a read port, captures
// each word and sends its four bytes little-endian, LSB-first within each byte.
module reg_dump_uart #(
  parameter int CLK_FREQ  = 12000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  clk_cnt;
  logic [CNT_W-1:0]  clk_cnt_nxt;
  logic [2:0]        bit_idx;
  logic [2:0]        bit_idx_nxt;
  logic [1:0]        byte_idx;
  logic [1:0]        byte_idx_nxt;
  logic [4:0]        reg_idx;
  logic [4:0]        reg_idx_nxt;
  logic [31:0]       shadow;
  logic [31:0]       shadow_nxt;
  logic              done_nxt;
  logic              bit_end;

  assign bit_end = (clk_cnt == CNT_LAST);

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      reg_idx  <= '0;
      shadow   <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      clk_cnt  <= clk_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      byte_idx <= byte_idx_nxt;
      reg_idx  <= reg_idx_nxt;
      shadow   <= shadow_nxt;
      done     <= done_nxt;
    end
  end

  // Next-state: every tx level holds for exactly CLKS_PER_BIT cycles
  always_comb begin
    state_nxt    = state;
    clk_cnt_nxt  = clk_cnt;
    bit_idx_nxt  = bit_idx;
    byte_idx_nxt = byte_idx;
    reg_idx_nxt  = reg_idx;
    shadow_nxt   = shadow;
    done_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = FETCH;
          reg_idx_nxt = '0;
          clk_cnt_nxt = '0;
        end
      end

      FETCH: begin
        shadow_nxt   = rf_data;
        byte_idx_nxt = '0;
        bit_idx_nxt  = '0;
        clk_cnt_nxt  = '0;
        state_nxt    = START;
      end

      START: begin
        if (bit_end) begin
          clk_cnt_nxt = '0;
          bit_idx_nxt = '0;
          state_nxt   = DATA;
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          clk_cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end

      STOP: begin
        if (bit_end) begin
          clk_cnt_nxt = '0;
          if (byte_idx != 2'd3) begin
            byte_idx_nxt = byte_idx + 2'd1;
            state_nxt    = START;
          end else if (reg_idx != 5'd31) begin
            reg_idx_nxt = reg_idx + 5'd1;
            state_nxt   = FETCH;
          end else begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state; {byte_idx, bit_idx} is the bit position in the word
  always_comb begin
    tx      = 1'b1;
    busy    = (state != IDLE);
    rf_addr = (state == IDLE) ? 5'd0 : reg_idx;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shadow[{byte_idx, bit_idx}];
      default: tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_reg_dump_uart.sv
// Bench for reg_dump_uart: cycle-accurate reference derived from dump timing
// arithmetic, plus byte decoding of the serial stream.
module tb_reg_dump_uart;

  localparam int CLK_FREQ = 12000000;
  localparam int BAUD     = 3000000;
  localparam int CPB      = 4;
  localparam int REG_CYC  = 1 + 40 * CPB;
  localparam int DUMP_CYC = 32 * REG_CYC + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        tx;
  logic        busy;
  logic        done;

  logic [31:0] rf     [32];
  logic [31:0] snap   [32];
  logic [7:0]  stream [128];

  int checks = 0;
  int errors = 0;

  assign rf_data = rf[rf_addr];

  always #5 clk = ~clk;

  reg_dump_uart #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .rf_addr(rf_addr),
    .rf_data(rf_data),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  task automatic chk(input string tag, input int t, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input int t, input logic exp_done);
    chk({tag, "_tx"}, t, 32'(tx), 32'd1);
    chk({tag, "_busy"}, t, 32'(busy), 32'd0);
    chk({tag, "_done"}, t, 32'(done), 32'(exp_done));
    chk({tag, "_addr"}, t, 32'(rf_addr), 32'd0);
  endtask

  task automatic randomize_rf();
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
  endtask

  // Entered at the negedge of cycle N with start already high for that cycle.
  task automatic run_dump(input bit pulses, input bit hold, input int abort_t, input bit wr_x5);
    int r, w, k, b, s;
    logic etx;
    for (int t = 1; t <= DUMP_CYC; t++) begin
      @(negedge clk);
      if (t == DUMP_CYC) begin
        chk_idle("end", t, 1'b1);
      end else begin
        r = (t - 1) / REG_CYC;
        w = (t - 1) % REG_CYC;
        k = w - 1;
        b = (w == 0) ? 0 : k / 40;
        s = (w == 0) ? 0 : (k % 40) / CPB;
        if (w == 0) snap[r] = rf[r];
        if (w == 0)      etx = 1'b1;
        else if (s == 0) etx = 1'b0;
        else if (s == 9) etx = 1'b1;
        else             etx = snap[r][8 * b + s - 1];
        chk("tx", t, 32'(tx), 32'(etx));
        chk("busy", t, 32'(busy), 32'd1);
        chk("done", t, 32'(done), 32'd0);
        chk("addr", t, 32'(rf_addr), 32'(r));
        if (w != 0 && s >= 1 && s <= 8 && (k % CPB) == CPB / 2)
          stream[4 * r + b][s - 1] = tx;
      end
      if (t == abort_t) begin
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk_idle("abort", t + 1, 1'b0);
        reset = 1'b0;
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          chk_idle("post_abort", t + 2 + j, 1'b0);
        end
        return;
      end
      start = hold || (pulses && (t == 50 || t == 3000));
      if (wr_x5 && t == 1 + 5 * REG_CYC + 1) rf[5] = 32'hAAAA_AAAA;
    end
    for (int i = 0; i < 128; i++)
      chk("byte", i, 32'(stream[i]), 32'((snap[i / 4] >> (8 * (i % 4))) & 32'hFF));
  endtask

  task automatic idle_tail(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      chk_idle("tail", j, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] exp_lo [4];
    logic [7:0] exp_hi [4];
    exp_lo = '{8'h78, 8'h56, 8'h34, 8'h12};
    exp_hi = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    reset = 1'b1;
    start = 1'b1;

    // Reset held two cycles with start high
    @(negedge clk);
    chk_idle("rst1", 0, 1'b0);
    @(negedge clk);
    chk_idle("rst2", 1, 1'b0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk_idle("rst_rel", 2, 1'b0);

    // Full dump with preloaded values and stray start pulses
    rf[1]  = 32'h1234_5678;
    rf[31] = 32'hDEAD_BEEF;
    @(negedge clk);
    chk_idle("pre1", 0, 1'b0);
    start = 1'b1;
    run_dump(1'b1, 1'b0, -1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("x1_byte", 4 + i, 32'(stream[4 + i]), 32'(exp_lo[i]));
      chk("x31_byte", 124 + i, 32'(stream[124 + i]), 32'(exp_hi[i]));
    end
    chk("x0_byte", 0, 32'(stream[0]), 32'h0);
    chk("x30_byte", 120, 32'(stream[120]), 32'h0);
    start = 1'b0;
    idle_tail(5);

    // Start held high: back-to-back dumps
    randomize_rf();
    start = 1'b1;
    run_dump(1'b0, 1'b1, -1, 1'b0);
    randomize_rf();
    run_dump(1'b0, 1'b0, -1, 1'b0);
    start = 1'b0;
    idle_tail(3);

    // Reset during x3 byte-2 data bits, then a clean dump from x0
    randomize_rf();
    start = 1'b1;
    run_dump(1'b0, 1'b0, 1 + 3 * REG_CYC + 100, 1'b0);
    randomize_rf();
    start = 1'b1;
    run_dump(1'b0, 1'b0, -1, 1'b0);
    start = 1'b0;
    idle_tail(3);

    // x5 rewritten after its capture
    randomize_rf();
    rf[5] = 32'h1111_1111;
    start = 1'b1;
    run_dump(1'b0, 1'b0, -1, 1'b1);
    for (int i = 20; i < 24; i++) chk("x5_byte", i, 32'(stream[i]), 32'h11);
    start = 1'b0;
    idle_tail(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
